// File: rtl/fir_flex_pkg.sv
// Shared FIR coefficient-path definitions: sequencer state encodings (also decoded
// by the SRAM access mux) and default geometry.
package fir_flex_pkg;

    localparam int TAP_NUM = 16;
    localparam int ADDR_W  = 4;

    typedef enum logic [1:0] {
        p_Idle   = 2'b00,
        p_Update = 2'b01,
        p_MemRd  = 2'b10,
        p_Drain  = 2'b11
    } fsmState_t;

endpackage

// File: rtl/tap_addr_cnt.sv
// Tap address counter: clearable, enabled, saturating at TAP_NUM-1 with a terminal flag.
module tap_addr_cnt #(
    parameter int TAP_NUM = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClr,
    input  logic              iEn,
    output logic [ADDR_W-1:0] oCnt,
    output logic              oTerm
);

    logic [ADDR_W-1:0] cnt;

    assign oTerm = (cnt == ADDR_W'(TAP_NUM - 1));
    assign oCnt  = cnt;

    always_ff @(posedge iClk) begin
        if (iRst)
            cnt <= '0;
        else if (iClr)
            cnt <= '0;
        else if (iEn && !oTerm)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/coeff_seq_ctrl.sv
// Coefficient SRAM sequencer: one 16-tap read sweep per accepted sample, with
// host ownership (Update) granted between sweeps and a 1-deep pending request.
module coeff_seq_ctrl
    import fir_flex_pkg::*;
#(
    parameter int TAP_NUM = fir_flex_pkg::TAP_NUM,
    parameter int ADDR_W  = fir_flex_pkg::ADDR_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iUpdateFlag,
    input  logic              iEnSample,
    output logic [1:0]        oCurState,
    output logic              oCsn_Fsm,
    output logic              oWrn_Fsm,
    output logic [ADDR_W-1:0] oAddr_Fsm,
    output logic              oRdValid,
    output logic [ADDR_W-1:0] oRdIdx,
    output logic              oSweepDone,
    output logic              oOverrun,
    output logic              oBusy
);

    fsmState_t         curState, nextState;
    logic              pending, pendingNext;
    logic              toMemRd;
    logic [ADDR_W-1:0] cnt;
    logic              cntTerm;

    tap_addr_cnt #(.TAP_NUM(TAP_NUM), .ADDR_W(ADDR_W)) uCnt (
        .iClk  (iClk),
        .iRst  (iRst),
        .iClr  (toMemRd),
        .iEn   (curState == p_MemRd),
        .oCnt  (cnt),
        .oTerm (cntTerm)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            curState   <= p_Idle;
            pending    <= 1'b0;
            oRdValid   <= 1'b0;
            oRdIdx     <= '0;
            oSweepDone <= 1'b0;
            oOverrun   <= 1'b0;
        end else begin
            curState   <= nextState;
            pending    <= pendingNext;
            oRdValid   <= (curState == p_MemRd);
            oRdIdx     <= cnt;
            oSweepDone <= (curState == p_MemRd) && cntTerm;
            oOverrun   <= iEnSample && pending && !toMemRd;
        end
    end

    always_comb begin
        nextState = curState;
        case (curState)
            p_Idle: begin
                if (iUpdateFlag)
                    nextState = p_Update;
                else if (iEnSample || pending)
                    nextState = p_MemRd;
            end
            p_Update: begin
                if (!iUpdateFlag)
                    nextState = p_Idle;
            end
            // a sweep always runs to completion; update requests wait for Drain
            p_MemRd: begin
                if (cntTerm)
                    nextState = p_Drain;
            end
            p_Drain: begin
                if (iUpdateFlag)
                    nextState = p_Update;
                else if (pending)
                    nextState = p_MemRd;
                else
                    nextState = p_Idle;
            end
            default: nextState = p_Idle;
        endcase

        toMemRd = (nextState == p_MemRd) && (curState != p_MemRd);

        // Entering MemRd consumes the latched request if there is one, so a
        // same-cycle sample stays latched; otherwise the new sample is consumed.
        if (toMemRd)
            pendingNext = iEnSample && pending;
        else
            pendingNext = pending || iEnSample;
    end

    assign oCurState = curState;
    assign oCsn_Fsm  = (curState != p_MemRd);
    assign oWrn_Fsm  = 1'b1;
    assign oAddr_Fsm = (curState == p_MemRd) ? cnt : '0;
    assign oBusy     = (curState != p_Idle);

endmodule

// File: tb/tb_coeff_seq_ctrl.sv
// Directed bench for coeff_seq_ctrl: table-driven Update/simultaneous-request
// vectors plus hand-written multi-cycle sweep, overrun and reset sequences.
module tb_coeff_seq_ctrl;

    localparam int TAPS = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uf  = 1'b0;
    logic          es  = 1'b0;
    logic [1:0]    curState;
    logic          csn, wrn, rdValid, sweepDone, overrun, busy;
    logic [AW-1:0] addr, rdIdx;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    coeff_seq_ctrl #(.TAP_NUM(TAPS), .ADDR_W(AW)) dut (
        .iClk        (clk),
        .iRst        (rst),
        .iUpdateFlag (uf),
        .iEnSample   (es),
        .oCurState   (curState),
        .oCsn_Fsm    (csn),
        .oWrn_Fsm    (wrn),
        .oAddr_Fsm   (addr),
        .oRdValid    (rdValid),
        .oRdIdx      (rdIdx),
        .oSweepDone  (sweepDone),
        .oOverrun    (overrun),
        .oBusy       (busy)
    );

    typedef struct {
        logic       uf;
        logic       es;
        logic [1:0] st;
        logic       csn;
        logic [3:0] addr;
        logic       rv;
        logic [3:0] idx;
        logic       done;
        logic       ovr;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic u, input logic e, input logic [1:0] st,
                                input logic c, input logic [3:0] a, input logic rv,
                                input logic [3:0] ix);
        vec_t v;
        v.uf = u; v.es = e; v.st = st; v.csn = c; v.addr = a;
        v.rv = rv; v.idx = ix; v.done = 1'b0; v.ovr = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // drive inputs, clock once, sample 1 time unit after the edge
    task automatic step(input logic u, input logic e);
        uf = u;
        es = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chkReset(input string nm);
        chk({nm, ".state"}, int'(curState), 0);
        chk({nm, ".csn"}, int'(csn), 1);
        chk({nm, ".wrn"}, int'(wrn), 1);
        chk({nm, ".addr"}, int'(addr), 0);
        chk({nm, ".rdValid"}, int'(rdValid), 0);
        chk({nm, ".rdIdx"}, int'(rdIdx), 0);
        chk({nm, ".done"}, int'(sweepDone), 0);
        chk({nm, ".ovr"}, int'(overrun), 0);
        chk({nm, ".busy"}, int'(busy), 0);
    endtask

    initial begin
        int dones;

        // Update held 5 cycles, then simultaneous update+sample with 3 update cycles
        vecs[0]  = mk(1, 0, 2'b01, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 2'b01, 1, 0, 0, 0);
        vecs[2]  = mk(1, 0, 2'b01, 1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 2'b01, 1, 0, 0, 0);
        vecs[4]  = mk(1, 0, 2'b01, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 2'b00, 1, 0, 0, 0);
        vecs[6]  = mk(1, 1, 2'b01, 1, 0, 0, 0);
        vecs[7]  = mk(1, 0, 2'b01, 1, 0, 0, 0);
        vecs[8]  = mk(1, 0, 2'b01, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 2'b00, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 2'b10, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 2'b10, 0, 1, 1, 0);

        // reset state
        rst = 1'b1;
        step(0, 1);
        step(0, 1);
        chkReset("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].uf, vecs[i].es);
            chk($sformatf("vec%0d.state", i), int'(curState), int'(vecs[i].st));
            chk($sformatf("vec%0d.csn", i), int'(csn), int'(vecs[i].csn));
            chk($sformatf("vec%0d.addr", i), int'(addr), int'(vecs[i].addr));
            chk($sformatf("vec%0d.rdValid", i), int'(rdValid), int'(vecs[i].rv));
            chk($sformatf("vec%0d.rdIdx", i), int'(rdIdx), int'(vecs[i].idx));
            chk($sformatf("vec%0d.done", i), int'(sweepDone), int'(vecs[i].done));
            chk($sformatf("vec%0d.ovr", i), int'(overrun), int'(vecs[i].ovr));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].st != 2'b00));
        end
        // let the sweep started from the latched request finish
        for (int k = 2; k < TAPS; k++) begin
            step(0, 0);
            chk($sformatf("simul.addr%0d", k), int'(addr), k);
        end
        step(0, 0);
        chk("simul.drainDone", int'(sweepDone), 1);
        step(0, 0);
        chk("simul.idle", int'(curState), 0);

        // single sweep
        step(0, 1);
        chk("single.t1.state", int'(curState), 2);
        chk("single.t1.addr", int'(addr), 0);
        chk("single.t1.csn", int'(csn), 0);
        chk("single.t1.rdValid", int'(rdValid), 0);
        for (int k = 1; k < TAPS; k++) begin
            step(0, 0);
            chk($sformatf("single.t%0d.addr", k + 1), int'(addr), k);
            chk($sformatf("single.t%0d.csn", k + 1), int'(csn), 0);
            chk($sformatf("single.t%0d.rdValid", k + 1), int'(rdValid), 1);
            chk($sformatf("single.t%0d.rdIdx", k + 1), int'(rdIdx), k - 1);
            chk($sformatf("single.t%0d.done", k + 1), int'(sweepDone), 0);
        end
        step(0, 0);
        chk("single.t17.state", int'(curState), 3);
        chk("single.t17.csn", int'(csn), 1);
        chk("single.t17.rdValid", int'(rdValid), 1);
        chk("single.t17.rdIdx", int'(rdIdx), 15);
        chk("single.t17.done", int'(sweepDone), 1);
        step(0, 0);
        chk("single.t18.state", int'(curState), 0);
        chk("single.t18.rdValid", int'(rdValid), 0);
        chk("single.t18.done", int'(sweepDone), 0);

        // update request rising mid-sweep waits for Drain
        for (int n = 1; n <= 19; n++) begin
            step(n >= 6 && n <= 18, n == 1);
            if (n <= 16) begin
                chk($sformatf("updMid.t%0d.state", n), int'(curState), 2);
                chk($sformatf("updMid.t%0d.addr", n), int'(addr), n - 1);
            end else if (n == 17) begin
                chk("updMid.t17.state", int'(curState), 3);
                chk("updMid.t17.done", int'(sweepDone), 1);
            end else if (n == 18) begin
                chk("updMid.t18.state", int'(curState), 1);
                chk("updMid.t18.csn", int'(csn), 1);
            end else begin
                chk("updMid.t19.state", int'(curState), 0);
            end
        end

        // back-to-back with overrun: samples at edges T0, T4, T6
        dones = 0;
        for (int n = 1; n <= 36; n++) begin
            step(0, n == 1 || n == 5 || n == 7);
            if (sweepDone) dones++;
            chk($sformatf("b2b.t%0d.ovr", n), int'(overrun), int'(n == 7));
            if (n == 17) chk("b2b.t17.state", int'(curState), 3);
            if (n == 18) begin
                chk("b2b.t18.state", int'(curState), 2);
                chk("b2b.t18.addr", int'(addr), 0);
            end
            if (n == 34) chk("b2b.t34.done", int'(sweepDone), 1);
            if (n == 35) chk("b2b.t35.state", int'(curState), 0);
        end
        chk("b2b.doneCount", dones, 2);

        // reset mid-sweep at T8
        step(0, 1);
        for (int n = 2; n <= 8; n++) step(0, 0);
        chk("rstMid.t8.addr", int'(addr), 7);
        rst = 1'b1;
        step(0, 0);
        chkReset("rstMid");
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            step(0, 0);
            if (sweepDone || rdValid || curState != 2'b00) dones++;
        end
        chk("rstMid.quiet", dones, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/coeff_seq_ctrl.md
# coeff_seq_ctrl

Sequencer for the FIR coefficient SP-SRAM. Owns the FSM state consumed by the SRAM access multiplexer and hands the SRAM to the host for coefficient update. Otherwise it issues one 16-tap read sweep per accepted input sample. It marks each returned coefficient with a valid strobe and tap index for the MAC datapath.

## Interface
- TAP_NUM, 16, taps per sweep = SRAM words read per sample
- ADDR_W, 4, SRAM address width; TAP_NUM ≤ 2^ADDR_W
- iClk  in  1  system clock; all logic on rising edge
- iRst  in  1  reset, synchronous, active-high
- iUpdateFlag  in  1  level; host requests SRAM ownership for coefficient writes
- iEnSample  in  1  1-cycle pulse; new input sample accepted, request one sweep
- oCurState  out  2  FSM state: Idle 2'b00, Update 2'b01, MemRd 2'b10, Drain 2'b11; drives the mux select
- oCsn_Fsm  out  1  SRAM chip select, active-low
- oWrn_Fsm  out  1  SRAM write enable, active-low; constant 1 (read only)
- oAddr_Fsm  out  ADDR_W  SRAM read address
- oRdValid  out  1  SRAM read data valid this cycle
- oRdIdx  out  ADDR_W  tap index of the data flagged by oRdValid
- oSweepDone  out  1  1-cycle pulse with the last tap's oRdValid
- oOverrun  out  1  1-cycle pulse; sample request lost
- oBusy  out  1  oCurState != Idle

## Operation
- Reset values (iRst=1 at an edge): oCurState=Idle, oCsn_Fsm=1, oWrn_Fsm=1, oAddr_Fsm=0, oRdValid=0, oRdIdx=0, oSweepDone=0, oOverrun=0, oBusy=0, pending=0.
- Reset mid-sweep aborts the sweep immediately. No further oRdValid and no oSweepDone.

State transitions:
- Idle:
  - iUpdateFlag=1 → Update. Update takes priority over a sample request.
  - else if iEnSample or pending → MemRd, with address counter = 0.
- Update:
  - Hold while iUpdateFlag=1.
  - iUpdateFlag=0 → Idle.
  - oCsn_Fsm=1 throughout.
- MemRd:
  - oCsn_Fsm=0, oAddr_Fsm=counter.
  - Counter increments every cycle.
  - At counter = TAP_NUM-1 → Drain.
  - iUpdateFlag is ignored until the sweep ends; a sweep is never preempted.
- Drain:
  - oCsn_Fsm=1.
  - iUpdateFlag → Update; else pending → MemRd with counter=0; else → Idle.

Read data path:
- oRdValid and oRdIdx are the registered copies of (state==MemRd, counter).
- This matches the 1-cycle SRAM read latency.

Pending request (1-deep):
- Set when iEnSample=1 and the request is not consumed by an Idle→MemRd transition that same cycle.
- Cleared on any transition into MemRd, unless iEnSample=1 in that same cycle; the new request then stays latched.
- iEnSample=1 while pending=1 and not being consumed → oOverrun pulse next cycle; pending stays 1.

Output decoding:
- oCsn_Fsm and oAddr_Fsm decode only state and counter registers; there is no input→output combinational path.
- The counter width is ADDR_W and it never wraps past TAP_NUM-1.

## Timing
- iEnSample high at edge T0 (Idle): MemRd from T1, oAddr_Fsm=0 at T1 … 15 at T16.
- oRdValid/oRdIdx 0 at T2 … 15 at T17. Drain at T17, oSweepDone=1 at T17, Idle at T18.
- Sweep latency: request to last coefficient = 17 cycles; SRAM held 16 cycles.
- Back-to-back: with pending=1 at Drain, the next MemRd starts at T18. Sustained throughput is one sweep per 17 cycles.
- Update entry: iUpdateFlag sampled at edge T → oCurState=Update after T. The mux switches the same cycle.
- iUpdateFlag rising during MemRd: Update entered from Drain, at most 17 cycles later.
- Simultaneous iUpdateFlag and iEnSample in Idle: Update wins, pending=1. The sweep starts one cycle after Update exits.

## Structure
- Shared package fir_flex_pkg holds:
  - state encodings p_Idle/p_Update/p_MemRd/p_Drain; these must match the access mux,
  - TAP_NUM, ADDR_W defaults.
- One natural sub-module: tap_addr_cnt. It is the clearable, enabled ADDR_W counter with a terminal-count flag at TAP_NUM-1.
- Everything else is a single FSM in coeff_seq_ctrl.

## Test plan
- Reset mid-sweep at T8: all outputs return to their reset values next cycle; no oSweepDone; Idle retained.
- Single sweep: iEnSample at T0 → oAddr_Fsm 0..15 at T1..T16, oCsn_Fsm=0 for exactly 16 cycles, oRdIdx 0..15 at T2..T17, oSweepDone at T17.
- Update: iUpdateFlag high 5 cycles in Idle → oCurState=01 for 5 cycles, oCsn_Fsm=1; then Idle.
- iUpdateFlag rises at T5 of a sweep → sweep completes all 16 reads; Update at T18.
- Back-to-back and overrun: iEnSample at T0, T4, T6 → second sweep MemRd at T18; oOverrun pulse at T7; exactly 2 oSweepDone pulses.
- Simultaneous iUpdateFlag and iEnSample in Idle: iUpdateFlag held 3 cycles → 3 Update cycles, then Idle, then MemRd with addr 0.
